// File: rtl/cic_interp_dac.sv
// CIC interpolator (x2**LOG2R, order N) feeding a saturated OUT_W-bit code to a sigma-delta DAC.
// Optional macro CIC_ROUND_EN: round half up instead of floor before saturation.
module cic_interp_dac #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 5,
  parameter int N     = 3,
  parameter int LOG2R = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  dat_in,
  input  logic                    dat_vld_in,
  output logic                    dat_rdy_out,
  output logic signed [OUT_W-1:0] dat_out,
  output logic                    dat_vld_out,
  output logic                    underrun_out
);

  localparam int CW    = IN_W + N;
  localparam int ACC_W = IN_W + N * LOG2R;
  localparam int SHIFT = (N - 1) * LOG2R + IN_W - OUT_W;
  localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W:0] MINV = -MAXV - 1;

  logic [LOG2R-1:0]           r_phase;
  logic                       w_slot;
  logic signed [CW-1:0]       w_sample;
  logic signed [CW-1:0]       r_comb;
  logic signed [ACC_W-1:0]    w_up;
  logic signed [ACC_W:0]      w_ext;
  logic signed [ACC_W:0]      w_sh;
  logic signed [OUT_W-1:0]    w_sat;
  logic signed [OUT_W-1:0]    r_sat;
  logic signed [OUT_W-1:0]    r_dat_out;
  logic                       r_underrun;
  logic [N+1:0]               r_take_pipe;
  logic                       r_vld;

  assign w_slot   = (r_phase == '0);
  assign w_sample = dat_vld_in ? {{N{dat_in[IN_W-1]}}, dat_in} : '0;

  // Low-rate comb chain: differences are formed combinationally and only
  // committed in the accept slot, so each stage's delay is one input sample.
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_comb
    logic signed [CW-1:0] w_x;
    logic signed [CW-1:0] w_y;
    logic signed [CW-1:0] r_prev;
    if (gi == 0) begin : g_first
      assign w_x = w_sample;
    end else begin : g_next
      assign w_x = g_comb[gi-1].w_y;
    end
    assign w_y = w_x - r_prev;
    always_ff @(posedge clk) begin
      if (rst)         r_prev <= '0;
      else if (w_slot) r_prev <= w_x;
    end
  end

  // Zero-stuffing: the comb result enters the integrators once per period.
  assign w_up = (r_phase == LOG2R'(1)) ? {{(ACC_W - CW){r_comb[CW-1]}}, r_comb} : '0;

  for (gi = 0; gi < N; gi++) begin : g_int
    logic signed [ACC_W-1:0] w_in;
    logic signed [ACC_W-1:0] r_acc;
    if (gi == 0) begin : g_first
      assign w_in = w_up;
    end else begin : g_next
      assign w_in = g_int[gi-1].r_acc;
    end
    always_ff @(posedge clk) begin
      if (rst) r_acc <= '0;
      else     r_acc <= r_acc + w_in;
    end
  end

`ifdef CIC_ROUND_EN
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) <<< (SHIFT - 1);
  assign w_ext = {g_int[N-1].r_acc[ACC_W-1], g_int[N-1].r_acc} + HALF;
`else
  assign w_ext = {g_int[N-1].r_acc[ACC_W-1], g_int[N-1].r_acc};
`endif

  assign w_sh = w_ext >>> SHIFT;

  always_comb begin
    w_sat = w_sh[OUT_W-1:0];
    if (w_sh > MAXV)      w_sat = MAXV[OUT_W-1:0];
    else if (w_sh < MINV) w_sat = MINV[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase     <= '0;
      r_comb      <= '0;
      r_sat       <= '0;
      r_dat_out   <= '0;
      r_underrun  <= 1'b0;
      r_take_pipe <= '0;
      r_vld       <= 1'b0;
    end else begin
      r_phase     <= r_phase + LOG2R'(1);
      if (w_slot) r_comb <= g_comb[N-1].w_y;
      r_sat       <= w_sat;
      r_dat_out   <= r_sat;
      r_underrun  <= w_slot && !dat_vld_in;
      // Valid follows the first real sample through the same N+2 stage pipeline.
      r_take_pipe <= {r_take_pipe[N:0], w_slot && dat_vld_in};
      r_vld       <= r_vld | r_take_pipe[N+1];
    end
  end

  assign dat_rdy_out  = w_slot;
  assign dat_out      = r_dat_out;
  assign dat_vld_out  = r_vld;
  assign underrun_out = r_underrun;

endmodule
